// File: rtl/eth_fcs_inserter_if.sv
// Byte-wide nibble bus (low nibble first on the wire) with a frame-valid strobe.
// master drives the bus, slave samples it.
interface eth_fcs_inserter_if;
  logic       tx_en;
  logic [3:0] data_lo;
  logic [3:0] data_hi;

  modport master (output tx_en, data_lo, data_hi);
  modport slave  (input  tx_en, data_lo, data_hi);
endinterface

// File: rtl/eth_fcs_inserter.sv
// Ethernet TX framer: passes preamble/data, pads short frames, appends CRC-32 FCS, enforces IFG.
// Latency 1 cycle; no backpressure -- input arriving during PAD/FCS/IFG is dropped and flagged as overrun.
module eth_fcs_inserter #(
  parameter int MIN_DATA  = 60,
  parameter bit PAD_EN    = 1'b1,
  parameter int IFG_BYTES = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  eth_fcs_inserter_if.slave          upstream,
  eth_fcs_inserter_if.master         downstream,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic                       overrun
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG} state_t;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [7:0]  SFD      = 8'hD5;
  localparam logic [10:0] MIN_CNT  = 11'(MIN_DATA);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

  state_t      state;
  logic [31:0] crc;
  logic [10:0] byte_cnt;
  logic [1:0]  fcs_idx;
  logic [15:0] ifg_cnt;

  logic [7:0]  din;
  logic [10:0] cnt_inc;
  logic [31:0] fcs_val;
  logic [7:0]  fcs_byte;

  assign din      = {upstream.data_hi, upstream.data_lo};
  assign cnt_inc  = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign fcs_val  = ~crc;
  assign fcs_byte = fcs_val[{fcs_idx, 3'b000} +: 8];

  // Reflected CRC-32, one input bit per iteration, LSB first.
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      crc                  <= CRC_INIT;
      byte_cnt             <= 11'd0;
      fcs_idx              <= 2'd0;
      ifg_cnt              <= 16'd0;
      busy                 <= 1'b0;
      frame_done           <= 1'b0;
      frame_err            <= 1'b0;
      overrun              <= 1'b0;
      downstream.tx_en     <= 1'b0;
      downstream.data_lo   <= 4'd0;
      downstream.data_hi   <= 4'd0;
    end else begin
      downstream.tx_en   <= 1'b0;
      downstream.data_lo <= 4'd0;
      downstream.data_hi <= 4'd0;
      frame_done         <= 1'b0;
      frame_err          <= 1'b0;
      overrun            <= 1'b0;

      case (state)
        IDLE: begin
          if (upstream.tx_en) begin
            downstream.tx_en                          <= 1'b1;
            {downstream.data_hi, downstream.data_lo}  <= din;
            crc                                       <= CRC_INIT;
            byte_cnt                                  <= 11'd0;
            busy                                      <= 1'b1;
            state                                     <= (din == SFD) ? DATA : PREAMBLE;
          end
        end

        PREAMBLE: begin
          if (upstream.tx_en) begin
            downstream.tx_en                          <= 1'b1;
            {downstream.data_hi, downstream.data_lo}  <= din;
            if (din == SFD) state <= DATA;
          end else begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        DATA: begin
          downstream.tx_en <= 1'b1;
          if (upstream.tx_en) begin
            {downstream.data_hi, downstream.data_lo}  <= din;
            crc                                       <= crc8(crc, din);
            byte_cnt                                  <= cnt_inc;
          end else if (PAD_EN && (byte_cnt < MIN_CNT)) begin
            // First pad byte goes out on the same edge the frame ends, so no gap.
            crc      <= crc8(crc, 8'h00);
            byte_cnt <= cnt_inc;
            fcs_idx  <= 2'd0;
            state    <= (cnt_inc >= MIN_CNT) ? FCS : PAD;
          end else begin
            {downstream.data_hi, downstream.data_lo}  <= fcs_val[7:0];
            fcs_idx                                   <= 2'd1;
            state                                     <= FCS;
          end
        end

        PAD: begin
          overrun          <= upstream.tx_en;
          downstream.tx_en <= 1'b1;
          crc              <= crc8(crc, 8'h00);
          byte_cnt         <= cnt_inc;
          fcs_idx          <= 2'd0;
          if (cnt_inc >= MIN_CNT) state <= FCS;
        end

        FCS: begin
          overrun                                   <= upstream.tx_en;
          downstream.tx_en                          <= 1'b1;
          {downstream.data_hi, downstream.data_lo}  <= fcs_byte;
          fcs_idx                                   <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            frame_done <= 1'b1;
            ifg_cnt    <= 16'd0;
            if (IFG_BYTES == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= IFG;
            end
          end
        end

        IFG: begin
          // Input on the final gap cycle is dropped silently; the frame must restart in IDLE.
          if (ifg_cnt == IFG_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            overrun <= upstream.tx_en;
            ifg_cnt <= ifg_cnt + 16'd1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
